// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core on a single unified memory bus.
// Define CPU_MC_PERF_COUNTERS_EN to add the cycle_count / instret_count ports.
module cpu_multicycle #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        retire,
   output logic        trap
`ifdef CPU_MC_PERF_COUNTERS_EN
   ,
   output logic [63:0] cycle_count,
   output logic [63:0] instret_count
`endif
);

   localparam int         IDXW  = $clog2(NUM_REGS);
   localparam logic [5:0] NREGS = 6'(NUM_REGS);

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0] target_q, target_d, alu_q, alu_d, mdr_q, mdr_d;
   logic [31:0] regFile_q [NUM_REGS];

   logic        regWe, memReqInt, memWeInt;
   logic [31:0] wbData, aluRes, opB, pcPlus4;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] immI, immS, immB, immJ;
   logic        isR, isI, isLw, isSw, isBr, isJal, legal, badIdx;

   assign opcode  = ir_q[6:0];
   assign rd      = ir_q[11:7];
   assign funct3  = ir_q[14:12];
   assign rs1     = ir_q[19:15];
   assign rs2     = ir_q[24:20];
   assign funct7  = ir_q[31:25];
   assign immI    = {{20{ir_q[31]}}, ir_q[31:20]};
   assign immS    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign immB    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign immJ    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign pcPlus4 = pc_q + 32'd4;

   // Only the listed funct combinations are legal; everything else traps in DECODE.
   assign isR   = (opcode == 7'b0110011) &&
                  ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b010 ||
                                             funct3 == 3'b110 || funct3 == 3'b111)) ||
                   (funct7 == 7'b0100000 && funct3 == 3'b000));
   assign isI   = (opcode == 7'b0010011) && (funct3 == 3'b000 || funct3 == 3'b010 ||
                                             funct3 == 3'b110 || funct3 == 3'b111);
   assign isLw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
   assign isSw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
   assign isBr  = (opcode == 7'b1100011) && (funct3 == 3'b000 || funct3 == 3'b001);
   assign isJal = (opcode == 7'b1101111);
   assign legal = isR || isI || isLw || isSw || isBr || isJal;

   // Index checks only look at the fields the instruction format actually uses.
   assign badIdx = ((isR || isI || isLw || isSw || isBr) && ({1'b0, rs1} >= NREGS)) ||
                   ((isR || isSw || isBr) && ({1'b0, rs2} >= NREGS)) ||
                   ((isR || isI || isLw || isJal) && ({1'b0, rd} >= NREGS));

   always_comb begin
      opB    = isR ? b_q : (isSw ? immS : immI);
      aluRes = a_q + opB;
      if (isJal) begin
         aluRes = pcPlus4;
      end else if (isR || isI) begin
         case (funct3)
            3'b000:  aluRes = (isR && funct7[5]) ? a_q - opB : a_q + opB;
            3'b010:  aluRes = {31'b0, $signed(a_q) < $signed(opB)};
            3'b110:  aluRes = a_q | opB;
            3'b111:  aluRes = a_q & opB;
            default: aluRes = a_q + opB;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      target_d  = target_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      regWe     = 1'b0;
      wbData    = isLw ? mdr_q : alu_q;
      memReqInt = 1'b0;
      memWeInt  = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = b_q;
      retire    = 1'b0;
      trap      = 1'b0;
      case (state_q)
         FETCH: begin
            memReqInt = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d      = regFile_q[rs1[IDXW-1:0]];
            b_d      = regFile_q[rs2[IDXW-1:0]];
            target_d = pc_q + (isJal ? immJ : immB);
            state_d  = (!legal || badIdx) ? TRAP : EXECUTE;
         end
         EXECUTE: begin
            alu_d = aluRes;
            if (isBr) begin
               pc_d    = ((a_q == b_q) ^ funct3[0]) ? target_q : pcPlus4;
               retire  = 1'b1;
               state_d = FETCH;
            end else begin
               state_d = (isLw || isSw) ? MEM : WRITEBACK;
            end
         end
         MEM: begin
            memReqInt = 1'b1;
            memWeInt  = isSw;
            mem_addr  = {alu_q[31:2], 2'b00};
            if (mem_ready) begin
               if (isSw) begin
                  pc_d    = pcPlus4;
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = WRITEBACK;
               end
            end
         end
         WRITEBACK: begin
            regWe   = (rd != 5'd0);
            pc_d    = isJal ? target_q : pcPlus4;
            retire  = 1'b1;
            state_d = FETCH;
         end
         TRAP: begin
            trap = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // The request is masked by reset so an in-flight access is dropped the moment reset asserts.
   assign mem_req = memReqInt & reset_n;
   assign mem_we  = memWeInt & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         target_q <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         target_q <= target_d;
         alu_q    <= alu_d;
         mdr_q    <= mdr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regFile_q[i] <= '0;
      end else if (regWe) begin
         regFile_q[rd[IDXW-1:0]] <= wbData;
      end
   end

`ifdef CPU_MC_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         cycle_count   <= cycle_count + 64'd1;
         instret_count <= instret_count + {63'd0, retire};
      end
   end
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: ALU vector table plus hand-written multi-cycle sequences.
module tb_cpu_multicycle;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        reset2_n = 1'b0;
   logic        memReq, memWe, memReady, retire, trap;
   logic [31:0] memAddr, memWdata, memRdata;
   logic        mem2Req, mem2We, retire2, trap2;
   logic [31:0] mem2Addr, mem2Wdata, mem2Rdata, prog2Word;
`ifdef CPU_MC_PERF_COUNTERS_EN
   logic [63:0] cycleCount, instretCount, cycleCount2, instretCount2;
`endif

   logic [31:0] mem [64];
   int          stallCycles = 0;
   int          waitCnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          misalignedCnt = 0;
   int          unstableCnt = 0;
   logic        waitPrev = 1'b0;
   logic        prevWe = 1'b0;
   logic [31:0] prevAddr = '0;
   logic [31:0] prevWdata = '0;

   localparam logic [6:0]  OP_IMM = 7'b0010011;
   localparam logic [6:0]  LOAD   = 7'b0000011;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] BAD    = 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] aVal;
      logic [31:0] bVal;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] expected;
   } aluVec_t;

   aluVec_t vecs [14];

   always #5 clk = ~clk;

   cpu_multicycle #(.RESET_PC(32'h0000_0000), .NUM_REGS(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .mem_ready(memReady), .retire(retire), .trap(trap)
`ifdef CPU_MC_PERF_COUNTERS_EN
      , .cycle_count(cycleCount), .instret_count(instretCount)
`endif
   );

   cpu_multicycle #(.RESET_PC(32'h0000_0100), .NUM_REGS(16)) dut2 (
      .clk(clk), .reset_n(reset2_n),
      .mem_req(mem2Req), .mem_we(mem2We), .mem_addr(mem2Addr), .mem_wdata(mem2Wdata),
      .mem_rdata(mem2Rdata), .mem_ready(1'b1), .retire(retire2), .trap(trap2)
`ifdef CPU_MC_PERF_COUNTERS_EN
      , .cycle_count(cycleCount2), .instret_count(instretCount2)
`endif
   );

   // Memory answers combinationally; ready rises after stallCycles waiting cycles of each access.
   assign memRdata  = mem[memAddr[7:2]];
   assign mem2Rdata = (mem2Addr == 32'h0000_0100) ? prog2Word : BAD;
   always_comb memReady = (stallCycles == 0) || (waitCnt >= stallCycles);

   always @(posedge clk) begin
      if (memReq && memReady) begin
         if (memWe) mem[memAddr[7:2]] <= memWdata;
         waitCnt <= 0;
      end else if (memReq) begin
         waitCnt <= waitCnt + 1;
      end else begin
         waitCnt <= 0;
      end
   end

   // Watches the bus for misaligned addresses and for outputs changing during a stalled access.
   always @(negedge clk) begin
      if (reset_n && memReq) begin
         if (memAddr[1:0] != 2'b00) misalignedCnt++;
         if (waitPrev && (memAddr != prevAddr || memWdata != prevWdata || memWe != prevWe))
            unstableCnt++;
      end
      waitPrev  = reset_n && memReq && !memReady;
      prevAddr  = memAddr;
      prevWdata = memWdata;
      prevWe    = memWe;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] encI(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] encS(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] encB(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] encJ(logic [20:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Holds reset for two cycles, releases it on a falling edge and parks on cycle 1.
   task automatic applyStimulus(input int stall);
      reset_n     = 1'b0;
      stallCycles = stall;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   // Counts sampled cycles (current one included) until n retire pulses, then moves on one cycle.
   task automatic runUntilRetire(input int n, input int maxCycles, output int cycles);
      int r;
      r      = 0;
      cycles = 0;
      while (1'b1) begin
         cycles++;
         if (retire) r++;
         if (r >= n || cycles >= maxCycles) break;
         stepCycles(1);
      end
      if (r < n) begin
         checks++;
         errors++;
         $display("[TB] FAIL retire_timeout: got %0d retires, expected %0d", r, n);
      end
      stepCycles(1);
   endtask

   task automatic loadProgramA();
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
      mem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, OP_IMM);
      mem[2] = encR(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
      mem[3] = encS(12'd8, 5'd3, 5'd0);
      mem[4] = encI(12'd8, 5'd0, 3'b010, 5'd4, LOAD);
      mem[5] = encS(12'd12, 5'd4, 5'd0);
      mem[6] = BAD;
   endtask

   initial begin
      int cyc;
      int rets;
      int nFetch;
      int reqCnt;
      int found;
      logic [31:0] fetchAddr [4];

      vecs[0]  = '{32'd5,        32'd7,        encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), NOP, 32'd12};
      vecs[1]  = '{32'hFFFFFFFF, 32'd1,        encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), NOP, 32'd0};
      vecs[2]  = '{32'd3,        32'd5,        encR(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), NOP, 32'hFFFFFFFE};
      vecs[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, encR(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), NOP, 32'hF000F000};
      vecs[4]  = '{32'h0F0F0000, 32'h000000F0, encR(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), NOP, 32'h0F0F00F0};
      vecs[5]  = '{32'hFFFFFFFF, 32'd1,        encR(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), NOP, 32'd1};
      vecs[6]  = '{32'd1,        32'hFFFFFFFF, encR(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), NOP, 32'd0};
      vecs[7]  = '{32'd5,        32'd5,        encR(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), NOP, 32'd0};
      vecs[8]  = '{32'd0,        32'd0,        encI(12'hFFF, 5'd1, 3'b000, 5'd3, OP_IMM), NOP, 32'hFFFFFFFF};
      vecs[9]  = '{32'h1234,     32'd0,        encI(12'h0FF, 5'd1, 3'b111, 5'd3, OP_IMM), NOP, 32'h34};
      vecs[10] = '{32'd5,        32'd0,        encI(12'hFF0, 5'd1, 3'b110, 5'd3, OP_IMM), NOP, 32'hFFFFFFF5};
      vecs[11] = '{32'h80000000, 32'd0,        encI(12'hFFF, 5'd1, 3'b010, 5'd3, OP_IMM), NOP, 32'd1};
      vecs[12] = '{32'd7,        32'd9,        encI(12'd0, 5'd1, 3'b000, 5'd0, OP_IMM),
                   encR(7'h00, 5'd2, 5'd0, 3'b000, 5'd3), 32'd9};
      vecs[13] = '{32'hCAFEF00D, 32'd0,        encI(12'h083, 5'd0, 3'b010, 5'd3, LOAD), NOP, 32'hCAFEF00D};
      prog2Word = encI(12'd1, 5'd0, 3'b000, 5'd20, OP_IMM);

      // Outputs held quiet during reset.
      loadProgramA();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_mem_req", memReq, 1'b0);
      checkOutput("rst_mem_we", memWe, 1'b0);
      checkOutput("rst_retire", retire, 1'b0);
      checkOutput("rst_trap", trap, 1'b0);

      // Reference program with a zero-wait memory.
      applyStimulus(0);
      checkOutput("first_fetch_req", memReq, 1'b1);
      checkOutput("first_fetch_addr", memAddr, 32'h0);
      runUntilRetire(5, 200, cyc);
      checkOutput("progA_cycles", cyc, 21);
      checkOutput("progA_mem8", mem[2], 32'd12);
      runUntilRetire(1, 50, cyc);
      checkOutput("progA_x4_stored", mem[3], 32'd12);
      stepCycles(2);
      checkOutput("progA_end_trap", trap, 1'b1);
      checkOutput("progA_end_req", memReq, 1'b0);

      // Same program with three wait cycles on every access.
      loadProgramA();
      unstableCnt = 0;
      applyStimulus(3);
      runUntilRetire(5, 300, cyc);
      checkOutput("stall_cycles", cyc, 42);
      checkOutput("stall_mem8", mem[2], 32'd12);
      runUntilRetire(1, 50, cyc);
      checkOutput("stall_x4_stored", mem[3], 32'd12);
      checkOutput("stall_bus_stable", unstableCnt, 0);

      // bne not taken then beq backwards.
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = encB(13'd8, 5'd1, 5'd1, 3'b001);
      mem[1] = encB(13'h1FFC, 5'd0, 5'd0, 3'b000);
      applyStimulus(0);
      nFetch = 0;
      rets   = 0;
      for (int c = 0; c < 7; c++) begin
         if (memReq && nFetch < 4) begin
            fetchAddr[nFetch] = memAddr;
            nFetch++;
         end
         if (retire) rets++;
         stepCycles(1);
      end
      checkOutput("br_fetch_count", nFetch, 3);
      checkOutput("br_pc0", fetchAddr[0], 32'h0);
      checkOutput("br_pc1", fetchAddr[1], 32'h4);
      checkOutput("br_pc2", fetchAddr[2], 32'h0);
      checkOutput("br_retires", rets, 2);

      // jal x1,+12 then store x1.
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = encJ(21'd12, 5'd1);
      mem[3] = encS(12'h040, 5'd1, 5'd0);
      mem[4] = BAD;
      applyStimulus(0);
      runUntilRetire(1, 50, cyc);
      checkOutput("jal_cycles", cyc, 4);
      checkOutput("jal_next_req", memReq, 1'b1);
      checkOutput("jal_next_addr", memAddr, 32'hC);
      runUntilRetire(1, 50, cyc);
      checkOutput("jal_link", mem[16], 32'd4);

      // ALU / immediate / x0 / misaligned-load table.
      for (int v = 0; v < 14; v++) begin
         for (int i = 0; i < 64; i++) mem[i] = '0;
         mem[0]  = encI(12'h080, 5'd0, 3'b010, 5'd1, LOAD);
         mem[1]  = encI(12'h084, 5'd0, 3'b010, 5'd2, LOAD);
         mem[2]  = vecs[v].op1;
         mem[3]  = vecs[v].op2;
         mem[4]  = encS(12'h088, 5'd3, 5'd0);
         mem[5]  = BAD;
         mem[32] = vecs[v].aVal;
         mem[33] = vecs[v].bVal;
         mem[34] = 32'hDEADBEEF;
         applyStimulus(0);
         runUntilRetire(5, 200, cyc);
         checkOutput($sformatf("alu_vec%0d", v), mem[34], vecs[v].expected);
      end
      checkOutput("bus_aligned", misalignedCnt, 0);

      // Illegal encodings trap after DECODE and keep the bus idle.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 64; i++) mem[i] = '0;
         mem[0] = (k == 0) ? BAD : encR(7'h20, 5'd2, 5'd1, 3'b111, 5'd3);
         applyStimulus(0);
         stepCycles(2);
         checkOutput($sformatf("illegal%0d_trap", k), trap, 1'b1);
         reqCnt = 0;
         rets   = 0;
         for (int c = 0; c < 5; c++) begin
            if (memReq) reqCnt++;
            if (retire) rets++;
            stepCycles(1);
         end
         checkOutput($sformatf("illegal%0d_no_req", k), reqCnt, 0);
         checkOutput($sformatf("illegal%0d_no_retire", k), rets, 0);
         checkOutput($sformatf("illegal%0d_trap_held", k), trap, 1'b1);
      end

      // RV32E-style core at RESET_PC=0x100: first fetch address, then trap on x20.
      @(negedge clk);
      reset2_n = 1'b1;
      #1;
      checkOutput("e_first_req", mem2Req, 1'b1);
      checkOutput("e_first_addr", mem2Addr, 32'h100);
      stepCycles(1);
      checkOutput("e_decode_no_trap", trap2, 1'b0);
      stepCycles(1);
      checkOutput("e_x20_trap", trap2, 1'b1);
      checkOutput("e_x20_no_req", mem2Req, 1'b0);
      checkOutput("e_x20_no_retire", retire2, 1'b0);

      // Reset pulse while a store is waiting in MEM.
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0]  = encI(12'd9, 5'd0, 3'b000, 5'd1, OP_IMM);
      mem[1]  = encS(12'h040, 5'd1, 5'd0);
      mem[16] = 32'h55;
      applyStimulus(3);
      found = 0;
      for (int c = 0; c < 100; c++) begin
         if (memReq && memWe) begin
            found = 1;
            break;
         end
         stepCycles(1);
      end
      checkOutput("sw_mem_reached", found, 1);
      checkOutput("sw_mem_addr", memAddr, 32'h40);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_req_low", memReq, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("abort_no_write", mem[16], 32'h55);
`ifdef CPU_MC_PERF_COUNTERS_EN
      checkOutput("perf_cycle_rst", cycleCount, 64'd0);
      checkOutput("perf_instret_rst", instretCount, 64'd0);
`endif
      reset_n = 1'b1;
      #1;
      checkOutput("abort_refetch_req", memReq, 1'b1);
      checkOutput("abort_refetch_addr", memAddr, 32'h0);
`ifdef CPU_MC_PERF_COUNTERS_EN
      checkOutput("perf_cycle_after", cycleCount, 64'd0);
      checkOutput("perf_instret_after", instretCount, 64'd0);
`endif
      checkOutput("abort_mem_kept", mem[16], 32'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
